nanorv32_axil_tbperiph: RTL and testbench

AXI4-Lite slave peripheral for the nanorv32 AXI simulation harness, sitting downstream of the core's AXI port beside the test memory. Provides:
- a buffered console character output;
- the tests-passed flag;
- a free-running cycle counter;
- the periodic timer interrupts feeding the core's irq input.

Replaces the ad-hoc counter and irq logic in the harness top level with a bus-visible block.

---
 rtl/nanorv32_tbperiph_pkg.sv | 11 +
 rtl/nanorv32_tbperiph_fifo.sv | 36 +++
 rtl/nanorv32_axil_tbperiph.sv | 124 ++++++++++++
 tb/tb_nanorv32_axil_tbperiph.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nanorv32_tbperiph_pkg.sv
// nanorv32_tbperiph_pkg: register map, pass magic and irq line indices for the harness peripheral.
`timescale 1ns/1ps
package nanorv32_tbperiph_pkg;
  localparam logic [9:0] REG_CONSOLE     = 10'h000;
  localparam logic [9:0] REG_TEST_RESULT = 10'h001;
  localparam logic [9:0] REG_IRQ_CTRL    = 10'h002;
  localparam logic [9:0] REG_CYCLE       = 10'h003;
  localparam logic [31:0] TEST_PASS_MAGIC = 32'd123456789;
  localparam int IRQ4_BIT = 4;
  localparam int IRQ5_BIT = 5;
endpackage

// File: rtl/nanorv32_tbperiph_fifo.sv
// nanorv32_tbperiph_fifo: synchronous byte FIFO with full/empty/level, head reads 0 when empty.
`timescale 1ns/1ps
module nanorv32_tbperiph_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign level = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/nanorv32_axil_tbperiph.sv
// nanorv32_axil_tbperiph: AXI4-Lite console, pass flag, cycle counter and timer irqs for the harness.
// Define TBPERIPH_IRQ_EN to enable irq[4]/irq[5] timers and the IRQ_CTRL register.
`timescale 1ns/1ps
module nanorv32_axil_tbperiph
  import nanorv32_tbperiph_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int IRQ4_LOG2 = 13,
  parameter int IRQ5_LOG2 = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [11:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [11:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_data,
  output logic        tests_passed,
  output logic [31:0] irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic aw_held, w_held, w_con, commit, push, pop, fifo_full, fifo_empty, unused;
  logic [11:0] aw_addr;
  logic [31:0] w_data, cycle, cycle_nxt, rd_map, irq_nxt;
  logic [3:0] w_strb;
  logic [9:0] w_idx, r_idx;
  logic [1:0] irq_en;
  logic [LW-1:0] level;
  assign unused = ^{mem_axi_awprot, mem_axi_arprot, aw_addr[1:0], mem_axi_araddr[1:0]};
  assign mem_axi_awready = !aw_held && !mem_axi_bvalid;
  assign mem_axi_wready = !w_held && !mem_axi_bvalid;
  assign mem_axi_arready = !mem_axi_rvalid;
  assign w_idx = aw_addr[11:2];
  assign r_idx = mem_axi_araddr[11:2];
  assign w_con = w_idx == REG_CONSOLE;
  // Fullness is the registered state, so a same-cycle pop never unblocks a pending push.
  assign commit = aw_held && w_held && !mem_axi_bvalid && !(w_con && fifo_full);
  assign push = commit && w_con && w_strb[0];
  assign pop = con_valid && con_ready;
  assign con_valid = !fifo_empty;
  assign cycle_nxt = cycle + 32'd1;
  assign rd_map = r_idx == REG_CONSOLE     ? {16'd0, 8'(level), 8'd0} :
                  r_idx == REG_TEST_RESULT ? {31'd0, tests_passed} :
                  r_idx == REG_IRQ_CTRL    ? {30'd0, irq_en} :
                  r_idx == REG_CYCLE       ? cycle : '0;
  nanorv32_tbperiph_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk), .resetn(resetn), .push(push), .pop(pop), .din(w_data[7:0]),
    .dout(con_data), .full(fifo_full), .empty(fifo_empty), .level(level)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      mem_axi_bvalid <= 1'b0;
      tests_passed <= 1'b0;
    end else begin
      if (mem_axi_awvalid && mem_axi_awready) begin
        aw_held <= 1'b1;
        aw_addr <= mem_axi_awaddr;
      end
      if (mem_axi_wvalid && mem_axi_wready) begin
        w_held <= 1'b1;
        w_data <= mem_axi_wdata;
        w_strb <= mem_axi_wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
      end
      if (commit && w_idx == REG_TEST_RESULT) tests_passed <= (w_strb == 4'hF) && (w_data == TEST_PASS_MAGIC);
      mem_axi_bvalid <= commit || (mem_axi_bvalid && !mem_axi_bready);
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata <= '0;
    end else begin
      if (mem_axi_arvalid && mem_axi_arready) mem_axi_rdata <= rd_map;
      mem_axi_rvalid <= (mem_axi_arvalid && mem_axi_arready) || (mem_axi_rvalid && !mem_axi_rready);
    end
  end
`ifdef TBPERIPH_IRQ_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq_en <= 2'b11;
    else if (commit && w_idx == REG_IRQ_CTRL && w_strb[0]) irq_en <= w_data[1:0];
  end
`else
  assign irq_en = 2'b00;
`endif
  // Decoded from the next count so each pulse lines up with the cycle CYCLE shows all ones.
  always_comb begin
    irq_nxt = '0;
    irq_nxt[IRQ4_BIT] = irq_en[0] && (&cycle_nxt[IRQ4_LOG2-1:0]);
    irq_nxt[IRQ5_BIT] = irq_en[1] && (&cycle_nxt[IRQ5_LOG2-1:0]);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle <= '0;
      irq <= '0;
    end else begin
      cycle <= cycle_nxt;
      irq <= irq_nxt;
    end
  end
endmodule

// File: tb/tb_nanorv32_axil_tbperiph.sv
// tb_nanorv32_axil_tbperiph: directed self-checking bench for the harness AXI-Lite peripheral.
`timescale 1ns/1ps
module tb_nanorv32_axil_tbperiph;
  logic clk = 1'b0;
  logic resetn;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [31:0] wdata, rdata, irq;
  logic [3:0] wstrb;
  logic con_valid, con_ready, tests_passed;
  logic [7:0] con_data;
  logic snap_cv;
  logic [7:0] snap_cd;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nanorv32_axil_tbperiph dut (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
    .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
    .tests_passed(tests_passed), .irq(irq)
  );

  task automatic do_reset;
    @(negedge clk);
    resetn = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; con_ready = 0; bready = 1; rready = 1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
    bit ao, wo, aw_done, w_done;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    while (!(aw_done && w_done) && n < 50) begin
      ao = awvalid && awready;
      wo = wvalid && wready;
      @(posedge clk); #1;
      if (ao) begin aw_done = 1; awvalid = 0; end
      if (wo) begin w_done = 1; wvalid = 0; end
      n++;
    end
    awvalid = 0; wvalid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bvalid && lat < 200);
    snap_cv = con_valid; snap_cd = con_data;
    if (!bvalid || !(aw_done && w_done)) lat = -1;
    else @(posedge clk);
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output int lat);
    bit ok;
    int n;
    n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1;
    do begin ok = arready; @(posedge clk); #1; n++; end while (!ok && n < 50);
    arvalid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid && lat < 50);
    d = rdata;
    if (!rvalid || !ok) lat = -1;
    else @(posedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    n_chk++; if ({awready, wready, arready, bvalid, rvalid, con_valid, tests_passed} !== 7'b1110000) begin n_fail++;
      $display("FAIL reset_flags: got %b expected 1110000", {awready, wready, arready, bvalid, rvalid, con_valid, tests_passed}); end
    n_chk++; if (rdata !== 32'd0 || con_data !== 8'd0) begin n_fail++; $display("FAIL reset_data: rdata %h con_data %h expected 0", rdata, con_data); end
    n_chk++; if (irq !== 32'd0) begin n_fail++; $display("FAIL reset_irq: got %h expected 0", irq); end
  endtask

  task automatic test_cycle;
    logic [31:0] d;
    int lat;
    do_reset();
    axi_read(12'h00C, d, lat);
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL read_latency: got %0d expected 1", lat); end
    n_chk++; if (d !== 32'd1) begin n_fail++; $display("FAIL cycle_first: got %h expected 1", d); end
    axi_read(12'h00C, d, lat);
    n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL cycle_second: got %h expected 3", d); end
    axi_read(12'h010, d, lat);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", d); end
    axi_read(12'h00A, d, lat);
`ifdef TBPERIPH_IRQ_EN
    n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL irq_ctrl_reset: got %h expected 3", d); end
`else
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL irq_ctrl_reset: got %h expected 0", d); end
`endif
  endtask

  task automatic test_console;
    int lat;
    con_ready = 1;
    axi_write(12'h000, 32'hDEAD_BE41, 4'h1, lat);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL console_bvalid_latency: got %0d expected 2", lat); end
    n_chk++; if (snap_cv !== 1'b1 || snap_cd !== 8'h41) begin n_fail++; $display("FAIL console_byte: valid %b data %h expected 1 41", snap_cv, snap_cd); end
    @(negedge clk);
    n_chk++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL console_one_cycle: con_valid %b expected 0", con_valid); end
    axi_write(12'h001, 32'h0000_0042, 4'h2, lat);
    n_chk++; if (lat != 2 || snap_cv !== 1'b0) begin n_fail++; $display("FAIL console_strb_ignored: lat %0d con_valid %b expected 2 0", lat, snap_cv); end
    con_ready = 0;
  endtask

  task automatic test_w_first;
    @(negedge clk);
    wdata = 32'd123456789; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1 wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if ({wready, bvalid} !== 2'b00) begin n_fail++; $display("FAIL w_first_hold: wready %b bvalid %b expected 0 0", wready, bvalid); end
    end
    awaddr = 12'h004; awvalid = 1;
    @(posedge clk); #1 awvalid = 0;
    @(negedge clk);
    n_chk++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL w_first_early_b: bvalid %b expected 0", bvalid); end
    @(negedge clk);
    n_chk++; if (bvalid !== 1'b1 || tests_passed !== 1'b1) begin n_fail++; $display("FAIL w_first_commit: bvalid %b tests_passed %b expected 1 1", bvalid, tests_passed); end
    @(posedge clk);
  endtask

  task automatic test_test_result;
    logic [31:0] d;
    int lat;
    axi_write(12'h004, 32'd0, 4'hF, lat);
    @(negedge clk);
    n_chk++; if (tests_passed !== 1'b0) begin n_fail++; $display("FAIL pass_clear: got %b expected 0", tests_passed); end
    axi_write(12'h004, 32'd123456789, 4'hF, lat);
    axi_read(12'h004, d, lat);
    n_chk++; if (tests_passed !== 1'b1 || d !== 32'd1) begin n_fail++; $display("FAIL pass_set: flag %b read %h expected 1 1", tests_passed, d); end
    axi_write(12'h004, 32'd0, 4'hF, lat);
    @(negedge clk);
    n_chk++; if (tests_passed !== 1'b0) begin n_fail++; $display("FAIL pass_write_zero: got %b expected 0", tests_passed); end
    axi_write(12'h004, 32'd123456789, 4'h1, lat);
    axi_read(12'h004, d, lat);
    n_chk++; if (tests_passed !== 1'b0 || d !== 32'd0) begin n_fail++; $display("FAIL pass_partial_strb: flag %b read %h expected 0 0", tests_passed, d); end
  endtask

  task automatic test_fifo_full;
    logic [31:0] d;
    logic [7:0] q[$];
    int lat, bad, bfirst;
    bad = 0; bfirst = -1;
    con_ready = 0;
    for (int k = 0; k < 16; k++) begin
      axi_write(12'h000, 32'h30 + k, 4'h1, lat);
      if (lat != 2) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL fill_latency: got %0d slow writes expected 0", bad); end
    axi_read(12'h000, d, lat);
    n_chk++; if (d !== 32'h0000_1000) begin n_fail++; $display("FAIL full_level: got %h expected 00001000", d); end
    @(negedge clk);
    awaddr = 12'h000; wdata = 32'h40; wstrb = 4'h1; awvalid = 1; wvalid = 1;
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    bad = 0;
    repeat (5) begin @(negedge clk); if (bvalid !== 1'b0) bad++; end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL full_stall: bvalid seen %0d times expected 0", bad); end
    con_ready = 1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (con_valid) q.push_back(con_data);
      if (bvalid && bfirst < 0) bfirst = i;
    end
    n_chk++; if (bfirst != 2) begin n_fail++; $display("FAIL full_release_b: bvalid at %0d expected 2", bfirst); end
    n_chk++; if (q.size() != 17) begin n_fail++; $display("FAIL drain_count: got %0d expected 17", q.size()); end
    bad = 0;
    foreach (q[k]) if (q[k] !== 8'(8'h30 + k)) bad++;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL drain_order: got %0d wrong bytes expected 0", bad); end
    con_ready = 0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    int lat;
    con_ready = 0;
    for (int k = 0; k < 3; k++) axi_write(12'h000, 32'h61 + k, 4'h1, lat);
    axi_read(12'h000, d, lat);
    n_chk++; if (d !== 32'h0000_0300) begin n_fail++; $display("FAIL level_three: got %h expected 00000300", d); end
    bready = 0;
    @(negedge clk);
    awaddr = 12'h010; wdata = 32'h0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (bvalid !== 1'b1 || con_valid !== 1'b1) begin n_fail++; $display("FAIL b_held: bvalid %b con_valid %b expected 1 1", bvalid, con_valid); end
    resetn = 0;
    #1;
    n_chk++; if (bvalid !== 1'b0 || con_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: bvalid %b con_valid %b expected 0 0", bvalid, con_valid); end
    repeat (2) @(negedge clk);
    resetn = 1; bready = 1;
    axi_read(12'h000, d, lat);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL level_after_reset: got %h expected 0", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    int lat, f4, f5, c4, c5, oth, any;
    f4 = -1; f5 = -1; c4 = 0; c5 = 0; oth = 0; any = 0;
`ifdef TBPERIPH_IRQ_EN
    do_reset();
    for (int j = 1; j <= 32'h10000; j++) begin
      @(negedge clk);
      if (irq[4]) begin c4++; if (f4 < 0) f4 = j; end
      if (irq[5]) begin c5++; if (f5 < 0) f5 = j; end
      if ((irq & ~32'h30) != 0) oth++;
    end
    n_chk++; if (f4 != 32'h1FFF || c4 != 8) begin n_fail++; $display("FAIL irq4_pulse: first %h count %0d expected 1fff 8", f4, c4); end
    n_chk++; if (f5 != 32'hFFFF || c5 != 1) begin n_fail++; $display("FAIL irq5_pulse: first %h count %0d expected ffff 1", f5, c5); end
    n_chk++; if (oth != 0) begin n_fail++; $display("FAIL irq_other_bits: got %0d expected 0", oth); end
    axi_write(12'h008, 32'd0, 4'h2, lat);
    axi_read(12'h008, d, lat);
    n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL irq_ctrl_strb: got %h expected 3", d); end
    axi_write(12'h008, 32'd0, 4'h1, lat);
    axi_read(12'h008, d, lat);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL irq_ctrl_write: got %h expected 0", d); end
    for (int j = 0; j < 32'h2000; j++) begin @(negedge clk); if (irq != 0) any++; end
    n_chk++; if (any != 0) begin n_fail++; $display("FAIL irq_disabled: pulses %0d expected 0", any); end
`else
    do_reset();
    for (int j = 0; j < 32'h2100; j++) begin @(negedge clk); if (irq !== 32'd0) any++; end
    n_chk++; if (any != 0) begin n_fail++; $display("FAIL irq_tied: pulses %0d expected 0", any); end
    axi_write(12'h008, 32'd3, 4'hF, lat);
    axi_read(12'h008, d, lat);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL irq_ctrl_absent: got %h expected 0", d); end
`endif
  endtask

  initial begin
    resetn = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1; con_ready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
    test_reset();
    test_cycle();
    test_console();
    test_w_first();
    test_test_result();
    test_fifo_full();
    test_reset_mid();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
